char_sequencer: RTL and testbench
=================================

# char_sequencer

Message buffer and playback sequencer sitting directly upstream of the letter-dial controller. Characters are keyed in one at a time on the 7-bit ASCII switches and captured with a load button. A go button then replays the stored message to the dial controller one character at a time. Each character uses a req/ready handshake and is followed by a fixed dwell so the character stays readable on the dial.

## Interface

Parameters:
- `DEPTH`, 16: message buffer entries; power of two, 2..64.
- `DWELL_CYCLES`, 100_000_000: cycles each character is held after the dial arrives (1 s at 100 MHz).
- `DEBOUNCE_CYCLES`, 1_000_000: cycles a raw button must be stable before its edge is accepted.

Ports:
- `clk`, in, 1: system clock. Everything is in this single clock domain.
- `reset_n`, in, 1: asynchronous, active-low reset.
- `ascii_in`, in, 7: character to capture, taken from the switches.
- `btn_load`, in, 1: raw load button. Asynchronous; the block synchronizes it.
- `btn_go`, in, 1: raw start/stop button. Asynchronous; the block synchronizes it.
- `dial_ready`, in, 1: dial controller idle / move complete.
- `dial_ascii`, out, 7: character presented to the dial controller.
- `dial_req`, out, 1: move request to the dial controller.
- `busy`, out, 1: playback in progress (any state other than IDLE).
- `fill`, out, log2(DEPTH)+1: number of stored characters.
- `empty`, out, 1: `fill == 0`.
- `full`, out, 1: `fill == DEPTH`.

## Operation

- **Buttons.** Each raw button goes through a 2-flop synchronizer and a debouncer. Each debounced rising edge produces exactly one 1-cycle pulse: `load_p` or `go_p`.
- **Buffer.** Linear array `buf[0..DEPTH-1]` with write count `fill`. The read index `rd_idx` is separate, so playback does not consume entries.
- **Loading.**
  - In IDLE, when `load_p` fires and the buffer is not full: `buf[fill] <= ascii_in` and `fill` increments.
  - `load_p` is dropped when the buffer is full or the block is not in IDLE.

States:
- **IDLE**
  - `go_p` with `!empty`: set `rd_idx <= 0` and go to ISSUE.
  - `go_p` with `empty`: ignored.
- **ISSUE**
  - Drive `dial_req=1` and `dial_ascii=buf[rd_idx]`.
  - When `dial_ready==0` is sampled (acceptance), drop `dial_req` and go to MOVE.
- **MOVE**
  - Hold `dial_ascii`.
  - When `dial_ready==1` is sampled, load the dwell timer with `DWELL_CYCLES-1` and go to DWELL.
- **DWELL**
  - The timer decrements every cycle.
  - At 0 with `stop_pend` set: go to IDLE.
  - At 0 with `rd_idx == fill-1` (last character): end-of-message handling, see Configuration.
  - Otherwise: `rd_idx++` and go to ISSUE.

Stop handling:
- `go_p` during playback sets `stop_pend`.
- The block never abandons a handshake: the current character always completes its dwell before the stop takes effect.
- `stop_pend` clears on entry to IDLE.

Other rules:
- `dial_ascii` stays stable from ISSUE entry through the end of DWELL.
- In IDLE, `dial_ascii` holds its last value.

## Timing

- All outputs are registered.
- Reset values:
  - `dial_ascii = 7'h20` (space, dial position 0)
  - `dial_req = 0`, `busy = 0`
  - `fill = 0`, `empty = 1`, `full = 0`
  - state IDLE, `rd_idx = 0`, `stop_pend = 0`
  - buffer contents are don't-care.
- Reset is honoured mid-operation: asserting `reset_n` low in any state returns the block to IDLE immediately and clears the buffer. The dial controller may be left mid-move.
- Button latency:
  - A debounced edge appears 2 synchronizer cycles plus `DEBOUNCE_CYCLES` after the raw edge settles.
  - `go_p` to `dial_req=1` takes 1 cycle.
- Handshake:
  - `dial_req` stays high for at least 1 cycle and until the first cycle `dial_ready==0` is sampled.
  - `dial_req` falls the cycle after that sample.
- Timer: the dwell lasts exactly `DWELL_CYCLES` cycles, from the MOVE→DWELL transition to the next ISSUE.
- Simultaneous `load_p` and `go_p` in IDLE: the load is performed and `go` is evaluated against the pre-load `fill`.

## Configuration

- `CHAR_SEQ_LOOP_EN` defined:
  - At the end of the message, set `rd_idx <= 0` and go to ISSUE. The message repeats indefinitely.
  - Only `go_p` (via `stop_pend`) or reset ends playback.
  - The buffer is retained on return to IDLE.
- `CHAR_SEQ_LOOP_EN` undefined:
  - At the end of the message, go to IDLE and clear `fill` to 0.
  - A stop via `stop_pend` also clears `fill`.

## Structure

- Shared package `char_seq_pkg` holds:
  - the state encoding: IDLE, ISSUE, MOVE, DWELL
  - `ASCII_SPACE = 7'h20`
- Sub-module `btn_pulse`: synchronizer, debounce counter and rising-edge detector, parameterized by `DEBOUNCE_CYCLES`. It is instantiated twice, once per button.
- The sequencer FSM, buffer and dwell timer live in `char_sequencer`.

## Test plan

Bench settings: `DEBOUNCE_CYCLES=4`, `DWELL_CYCLES=8`, and a dial model that drops ready 1 cycle after req and raises it 20 cycles later.

1. **Load and play.** Load "h","i" (7'h68, 7'h69), then `go`.
   - Expect `fill=2`.
   - Expect `dial_ascii` 7'h68 then 7'h69, each with one req pulse.
   - Expect ISSUE-to-ISSUE spacing of exactly 8 dwell cycles.
   - Expect `fill=0` and `busy=0` at the end (loop disabled).
2. **Full buffer.** Load 17 characters with `DEPTH=16`.
   - Expect `full=1` and `fill=16`.
   - Expect the 17th character absent on playback.
3. **Ignored inputs.**
   - `go` with an empty buffer: `dial_req` stays 0 and `busy` stays 0.
   - `load` during playback: `fill` unchanged.
4. **Stop mid-message.** Press `go` while character 1 of 3 is in MOVE.
   - Expect character 1 to complete its dwell.
   - Expect no req for character 2, and return to IDLE.
5. **Reset mid-MOVE.** Assert `reset_n` low during MOVE.
   - Expect `dial_req=0`, `dial_ascii=7'h20`, `fill=0` and `empty=1` immediately.
6. **Loop mode and bounce.** With `CHAR_SEQ_LOOP_EN` defined and 2 characters loaded:
   - Expect `dial_ascii` to wrap 7'h68→7'h69→7'h68.
   - A bouncing `go` (3 glitches shorter than 4 cycles) yields one stop.

Source files
------------

// File: rtl/char_seq_pkg.sv
// Shared types for the character playback sequencer: FSM state encoding
// and the dial's home character.
package char_seq_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_MOVE  = 2'd2,
      ST_DWELL = 2'd3
   } seq_state_e;

   localparam logic [6:0] ASCII_SPACE = 7'h20;

endpackage

// File: rtl/btn_pulse.sv
// Raw push-button conditioner: 2-flop synchronizer, stability debouncer and
// rising-edge detector producing a single registered 1-cycle pulse.
module btn_pulse #(
   parameter int DEBOUNCE_CYCLES = 1_000_000
) (
   input  logic clk,
   input  logic reset_n,
   input  logic btn,
   output logic pulse
);

   localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   logic [1:0]       sync_r;
   logic             stable_r;
   logic [CNT_W-1:0] cnt_r;
   logic             pulse_r;

   // Synchronize, require DEBOUNCE_CYCLES consecutive disagreeing samples, pulse on accepted rise
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sync_r   <= 2'b00;
         stable_r <= 1'b0;
         cnt_r    <= '0;
         pulse_r  <= 1'b0;
      end else begin
         sync_r  <= {sync_r[0], btn};
         pulse_r <= 1'b0;
         if (sync_r[1] == stable_r) begin
            cnt_r <= '0;
         end else if (cnt_r == CNT_LAST) begin
            cnt_r    <= '0;
            stable_r <= sync_r[1];
            pulse_r  <= sync_r[1];
         end else begin
            cnt_r <= cnt_r + CNT_ONE;
         end
      end
   end

   assign pulse = pulse_r;

endmodule

// File: rtl/char_sequencer.sv
// Message buffer and playback sequencer feeding the letter-dial controller.
// Optional build macro CHAR_SEQ_LOOP_EN: replay the message until stopped.
module char_sequencer
   import char_seq_pkg::*;
#(
   parameter int DEPTH           = 16,
   parameter int DWELL_CYCLES    = 100_000_000,
   parameter int DEBOUNCE_CYCLES = 1_000_000
) (
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic [6:0]               ascii_in,
   input  logic                     btn_load,
   input  logic                     btn_go,
   input  logic                     dial_ready,
   output logic [6:0]               dial_ascii,
   output logic                     dial_req,
   output logic                     busy,
   output logic [$clog2(DEPTH):0]   fill,
   output logic                     empty,
   output logic                     full
);

   localparam int IDX_W  = $clog2(DEPTH);
   localparam int FILL_W = IDX_W + 1;
   localparam int TMR_W  = $clog2(DWELL_CYCLES + 1);

   localparam logic [FILL_W-1:0] FILL_ONE   = FILL_W'(1);
   localparam logic [FILL_W-1:0] FILL_DEPTH = FILL_W'(DEPTH);
   localparam logic [IDX_W-1:0]  IDX_ONE    = IDX_W'(1);
   localparam logic [TMR_W-1:0]  TMR_ONE    = TMR_W'(1);
   localparam logic [TMR_W-1:0]  TMR_LOAD   = TMR_W'(DWELL_CYCLES - 1);

   seq_state_e        state_r, state_n;
   logic [IDX_W-1:0]  rd_idx_r, rd_idx_n;
   logic [FILL_W-1:0] fill_r, fill_n;
   logic [TMR_W-1:0]  timer_r, timer_n;
   logic              stop_pend_r, stop_pend_n;
   logic              dial_req_r, dial_req_n;
   logic [6:0]        dial_ascii_r, dial_ascii_n;
   logic              busy_r, empty_r, full_r;
   logic              wr_en_s, last_s;
   logic              load_p_s, go_p_s;
   logic [6:0]        msg_buf_r [DEPTH];

   btn_pulse #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_load_btn (
      .clk     (clk),
      .reset_n (reset_n),
      .btn     (btn_load),
      .pulse   (load_p_s)
   );

   btn_pulse #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_go_btn (
      .clk     (clk),
      .reset_n (reset_n),
      .btn     (btn_go),
      .pulse   (go_p_s)
   );

   assign last_s = ({1'b0, rd_idx_r} == (fill_r - FILL_ONE));

   // Next-state, buffer bookkeeping and output next-values
   always_comb begin
      state_n      = state_r;
      rd_idx_n     = rd_idx_r;
      fill_n       = fill_r;
      timer_n      = timer_r;
      stop_pend_n  = stop_pend_r;
      dial_req_n   = dial_req_r;
      dial_ascii_n = dial_ascii_r;
      wr_en_s      = 1'b0;

      if (go_p_s && (state_r != ST_IDLE)) begin
         stop_pend_n = 1'b1;
      end else begin
         stop_pend_n = stop_pend_r;
      end

      case (state_r)
         ST_IDLE: begin
            stop_pend_n = 1'b0;
            if (load_p_s && !full_r) begin
               wr_en_s = 1'b1;
               fill_n  = fill_r + FILL_ONE;
            end else begin
               wr_en_s = 1'b0;
            end
            // go is judged on the pre-load count so a same-cycle load cannot start playback
            if (go_p_s && !empty_r) begin
               rd_idx_n   = '0;
               dial_req_n = 1'b1;
               state_n    = ST_ISSUE;
            end else begin
               state_n = ST_IDLE;
            end
         end
         ST_ISSUE: begin
            if (!dial_ready) begin
               dial_req_n = 1'b0;
               state_n    = ST_MOVE;
            end else begin
               dial_req_n = 1'b1;
            end
         end
         ST_MOVE: begin
            if (dial_ready) begin
               timer_n = TMR_LOAD;
               state_n = ST_DWELL;
            end else begin
               state_n = ST_MOVE;
            end
         end
         ST_DWELL: begin
            if (timer_r != '0) begin
               timer_n = timer_r - TMR_ONE;
            end else if (stop_pend_r) begin
               stop_pend_n = 1'b0;
               state_n     = ST_IDLE;
`ifndef CHAR_SEQ_LOOP_EN
               fill_n      = '0;
`endif
            end else if (last_s) begin
`ifdef CHAR_SEQ_LOOP_EN
               rd_idx_n    = '0;
               dial_req_n  = 1'b1;
               state_n     = ST_ISSUE;
`else
               stop_pend_n = 1'b0;
               fill_n      = '0;
               state_n     = ST_IDLE;
`endif
            end else begin
               rd_idx_n   = rd_idx_r + IDX_ONE;
               dial_req_n = 1'b1;
               state_n    = ST_ISSUE;
            end
         end
         default: begin
            dial_req_n = 1'b0;
            state_n    = ST_IDLE;
         end
      endcase

      // The character is latched once on ISSUE entry and held through MOVE and DWELL
      if ((state_n == ST_ISSUE) && (state_r != ST_ISSUE)) begin
         dial_ascii_n = msg_buf_r[rd_idx_n];
      end else begin
         dial_ascii_n = dial_ascii_r;
      end
   end

   // State, counters and registered outputs
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_r      <= ST_IDLE;
         rd_idx_r     <= '0;
         fill_r       <= '0;
         timer_r      <= '0;
         stop_pend_r  <= 1'b0;
         dial_req_r   <= 1'b0;
         dial_ascii_r <= ASCII_SPACE;
         busy_r       <= 1'b0;
         empty_r      <= 1'b1;
         full_r       <= 1'b0;
      end else begin
         state_r      <= state_n;
         rd_idx_r     <= rd_idx_n;
         fill_r       <= fill_n;
         timer_r      <= timer_n;
         stop_pend_r  <= stop_pend_n;
         dial_req_r   <= dial_req_n;
         dial_ascii_r <= dial_ascii_n;
         busy_r       <= (state_n != ST_IDLE);
         empty_r      <= (fill_n == '0);
         full_r       <= (fill_n == FILL_DEPTH);
      end
   end

   // Message storage; contents are don't-care after reset
   always_ff @(posedge clk) begin
      if (wr_en_s) begin
         msg_buf_r[fill_r[IDX_W-1:0]] <= ascii_in;
      end
   end

   assign dial_ascii = dial_ascii_r;
   assign dial_req   = dial_req_r;
   assign busy       = busy_r;
   assign fill       = fill_r;
   assign empty      = empty_r;
   assign full       = full_r;

endmodule

// File: tb/tb_char_sequencer.sv
// Directed/randomized bench for char_sequencer with a reactive dial model and
// a message-level reference model (queue of stored characters).
module tb_char_sequencer;

   localparam int DEPTH = 16;
   localparam int DWELL = 8;
   localparam int DEB   = 4;

   logic       clk = 1'b0;
   logic       reset_n;
   logic [6:0] ascii_in;
   logic       btn_load;
   logic       btn_go;
   logic       dial_ready;
   logic [6:0] dial_ascii;
   logic       dial_req;
   logic       busy;
   logic [4:0] fill;
   logic       empty;
   logic       full;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   logic [6:0] msg[$];
   logic [6:0] issued[$];

   char_sequencer #(.DEPTH(DEPTH), .DWELL_CYCLES(DWELL), .DEBOUNCE_CYCLES(DEB)) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .ascii_in   (ascii_in),
      .btn_load   (btn_load),
      .btn_go     (btn_go),
      .dial_ready (dial_ready),
      .dial_ascii (dial_ascii),
      .dial_req   (dial_req),
      .busy       (busy),
      .fill       (fill),
      .empty      (empty),
      .full       (full)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Dial controller: ready drops 1 cycle after req, rises 20 cycles later
   int mv_cnt = 0;
   always @(negedge clk) begin
      if (reset_n !== 1'b1) begin
         dial_ready = 1'b1;
         mv_cnt     = 0;
      end else if (mv_cnt > 0) begin
         mv_cnt--;
         if (mv_cnt == 0) dial_ready = 1'b1;
      end else if (dial_req && dial_ready) begin
         dial_ready = 1'b0;
         mv_cnt     = 20;
      end
   end

   // Monitor: records each presented character and measures dwell length
   int   rdy_rise  = 0;
   bit   armed     = 0;
   logic prev_req  = 1'b0;
   logic prev_rdy  = 1'b1;
   logic prev_busy = 1'b0;
   always @(posedge clk) begin
      cyc++;
      #1;
      if (reset_n !== 1'b1) begin
         armed     = 0;
         prev_req  = 1'b0;
         prev_rdy  = 1'b1;
         prev_busy = 1'b0;
      end else begin
         if (dial_req && !prev_req) begin
            issued.push_back(dial_ascii);
            if (armed) chk("dwell_gap", cyc - rdy_rise, DWELL);
            armed = 0;
         end
         if (dial_ready && !prev_rdy && busy) begin
            rdy_rise = cyc;
            armed    = 1;
         end
         if (!busy && prev_busy && armed) begin
            chk("end_dwell", cyc - rdy_rise, DWELL);
            armed = 0;
         end
         if (busy && issued.size() > 0) chk("ascii_hold", dial_ascii, issued[$]);
         prev_req  = dial_req;
         prev_rdy  = dial_ready;
         prev_busy = busy;
      end
   end

   task automatic cycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic press(input bit is_go);
      if (is_go) btn_go = 1'b1; else btn_load = 1'b1;
      cycles(10);
      btn_go   = 1'b0;
      btn_load = 1'b0;
      cycles(10);
   endtask

   task automatic bounce_go();
      repeat (3) begin
         btn_go = 1'b1;
         cycles(2);
         btn_go = 1'b0;
         cycles(2);
      end
      press(1'b1);
   endtask

   task automatic load_char(input logic [6:0] c, input bit stored);
      ascii_in = c;
      press(1'b0);
      if (stored) msg.push_back(c);
   endtask

   task automatic go_start();
      int n = 0;
      btn_go = 1'b1;
      while (!busy && n < 30) begin
         cycles(1);
         n++;
      end
      chk("start_timeout", busy, 1'b1);
      btn_go = 1'b0;
      cycles(8);
   endtask

   task automatic wait_idle(input int bound);
      int n = 0;
      while (busy && n < bound) begin
         cycles(1);
         n++;
      end
      chk("idle_timeout", busy, 1'b0);
   endtask

   task automatic wait_move(input int bound);
      int n = 0;
      while (!(busy && !dial_ready && !dial_req) && n < bound) begin
         cycles(1);
         n++;
      end
      chk("move_timeout", dial_ready, 1'b0);
   endtask

   // Played sequence must be the stored message, once, in order
   task automatic check_once(input string tag, input logic [6:0] exp_q[$]);
      chk({tag, "_count"}, issued.size(), exp_q.size());
      for (int i = 0; i < issued.size() && i < exp_q.size(); i++)
         chk({tag, "_char"}, issued[i], exp_q[i]);
      issued.delete();
   endtask

   // Played sequence must be the stored message repeated cyclically
   task automatic check_loop(input string tag, input logic [6:0] exp_q[$]);
      for (int i = 0; i < issued.size(); i++)
         chk({tag, "_char"}, issued[i], exp_q[i % exp_q.size()]);
      issued.delete();
   endtask

   task automatic do_reset();
      reset_n = 1'b0;
      cycles(3);
      reset_n = 1'b1;
      cycles(2);
      msg.delete();
      issued.delete();
   endtask

   initial begin
      int len;
      reset_n  = 1'b0;
      ascii_in = 7'h00;
      btn_load = 1'b0;
      btn_go   = 1'b0;
      cycles(3);
      chk("rst_ascii", dial_ascii, 7'h20);
      chk("rst_req", dial_req, 1'b0);
      chk("rst_busy", busy, 1'b0);
      chk("rst_fill", fill, 5'd0);
      chk("rst_empty", empty, 1'b1);
      chk("rst_full", full, 1'b0);
      reset_n = 1'b1;
      cycles(2);

`ifndef CHAR_SEQ_LOOP_EN
      // Load and play "hi"
      load_char(7'h68, 1'b1);
      load_char(7'h69, 1'b1);
      chk("t1_fill", fill, 5'd2);
      chk("t1_empty", empty, 1'b0);
      go_start();
      wait_idle(400);
      check_once("t1_seq", msg);
      chk("t1_fill_end", fill, 5'd0);
      chk("t1_empty_end", empty, 1'b1);
      msg.delete();

      // Full buffer: 17th random character dropped
      for (int i = 0; i < DEPTH + 1; i++)
         load_char(7'($urandom_range(0, 127)), (i < DEPTH));
      chk("t2_full", full, 1'b1);
      chk("t2_fill", fill, 5'd16);
      go_start();
      wait_idle(1500);
      check_once("t2_seq", msg);
      chk("t2_fill_end", fill, 5'd0);
      msg.delete();

      // go with empty buffer is ignored
      press(1'b1);
      chk("t3_go_empty_busy", busy, 1'b0);
      chk("t3_go_empty_req", dial_req, 1'b0);
      chk("t3_go_empty_issued", issued.size(), 0);

      // load during playback is ignored
      for (int i = 0; i < 3; i++) load_char(7'($urandom_range(0, 127)), 1'b1);
      go_start();
      load_char(7'h7A, 1'b0);
      chk("t3_load_busy_fill", fill, 5'd3);
      wait_idle(600);
      check_once("t3_seq", msg);
      msg.delete();

      // Stop while character 1 of 3 is moving
      for (int i = 0; i < 3; i++) load_char(7'($urandom_range(0, 127)), 1'b1);
      go_start();
      wait_move(40);
      press(1'b1);
      wait_idle(400);
      while (msg.size() > 1) void'(msg.pop_back());
      check_once("t4_seq", msg);
      chk("t4_fill_end", fill, 5'd0);
      msg.delete();

      // Reset during MOVE
      load_char(7'h41, 1'b1);
      load_char(7'h42, 1'b1);
      go_start();
      wait_move(40);
      reset_n = 1'b0;
      #1;
      chk("t5_req", dial_req, 1'b0);
      chk("t5_ascii", dial_ascii, 7'h20);
      chk("t5_fill", fill, 5'd0);
      chk("t5_empty", empty, 1'b1);
      chk("t5_busy", busy, 1'b0);
      cycles(3);
      reset_n = 1'b1;
      cycles(2);
      msg.delete();
      issued.delete();

      // Random message started by a bouncing go: a single start, full replay
      len = $urandom_range(2, 6);
      for (int i = 0; i < len; i++) load_char(7'($urandom_range(0, 127)), 1'b1);
      chk("t7_fill", fill, 5'(len));
      bounce_go();
      wait_idle(600);
      check_once("t7_seq", msg);
      chk("t7_fill_end", fill, 5'd0);
`else
      // Loop mode: "hi" wraps until stopped
      load_char(7'h68, 1'b1);
      load_char(7'h69, 1'b1);
      chk("t6_fill", fill, 5'd2);
      go_start();
      for (int n = 0; n < 300 && issued.size() < 3; n++) cycles(1);
      chk("t6_wrap_count", (issued.size() >= 3), 1'b1);
      if (issued.size() >= 3) begin
         chk("t6_wrap0", issued[0], 7'h68);
         chk("t6_wrap1", issued[1], 7'h69);
         chk("t6_wrap2", issued[2], 7'h68);
      end
      bounce_go();
      wait_idle(300);
      chk("t6_fill_kept", fill, 5'd2);
      check_loop("t6_seq", msg);
      // A bouncing start must not also register as a stop
      bounce_go();
      cycles(150);
      chk("t6_still_busy", busy, 1'b1);
      press(1'b1);
      wait_idle(300);
      chk("t6_fill_kept2", fill, 5'd2);
      check_loop("t6_seq2", msg);
      do_reset();
      chk("t6_rst_fill", fill, 5'd0);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #900_000;
      $display("FAIL global_timeout: observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule
